// File: rtl/fp_pkg.sv
// Shared single-precision constants and divider FSM state type for the FP ALU.
package fp_pkg;

    localparam int unsigned FP_BIAS     = 127;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
    localparam logic [31:0] FP_RES_EXC  = 32'hFFFF_FFFF;
    localparam int unsigned FPDIV_QBITS = 26;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORM,
        DONE
    } fpdiv_state_e;

endpackage

// File: rtl/fp_div_special.sv
// Operand classification for fp_div: zero / all-ones exponent detection and the
// special-case result and flags that resolve on the accept edge.
module fp_div_special
    import fp_pkg::*;
(
    input  logic [31:0] n1,
    input  logic [31:0] n2,
    output logic        special,
    output logic [31:0] sp_result,
    output logic        sp_exc,
    output logic        sp_dbz
);

    logic sign;
    logic z1, z2, inf1, inf2;

    always_comb begin
        sign      = n1[31] ^ n2[31];
        z1        = (n1[30:23] == 8'h00);
        z2        = (n2[30:23] == 8'h00);
        inf1      = (n1[30:23] == FP_EXP_MAX);
        inf2      = (n2[30:23] == FP_EXP_MAX);
        special   = 1'b0;
        sp_result = '0;
        sp_exc    = 1'b0;
        sp_dbz    = 1'b0;
        // Denormal operands are treated as zero; their mantissa is ignored.
        if (inf1 || inf2 || (z1 && z2)) begin
            special   = 1'b1;
            sp_exc    = 1'b1;
            sp_result = FP_RES_EXC;
        end else if (z2) begin
            special   = 1'b1;
            sp_dbz    = 1'b1;
            sp_result = {sign, FP_EXP_MAX, 23'b0};
        end else if (z1) begin
            special   = 1'b1;
            sp_result = {sign, 31'b0};
        end
    end

endmodule

// File: rtl/fp_div.sv
// Iterative single-precision divider, radix-2 restoring, one quotient bit per clock.
// Optional macro FPDIV_RNE_EN selects round-to-nearest-even; otherwise truncates.
module fp_div
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] n1,
    input  logic [31:0] n2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Overflow,
    output logic        Underflow,
    output logic        Exception,
    output logic        DivByZero
);

    fpdiv_state_e state_q, state_d;
    logic [25:0]  rem_q, rem_d;
    logic [23:0]  b_q, b_d;
    logic [25:0]  q_q, q_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         sign_q, sign_d;
    logic [9:0]   exp_q, exp_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  result_q, result_d;
    logic         ovf_q, ovf_d, unf_q, unf_d, exc_q, exc_d, dbz_q, dbz_d;

    logic         special, sp_exc, sp_dbz;
    logic [31:0]  sp_result;

    logic         qbit;
    logic [25:0]  rem_sub;
    logic [22:0]  mant;
    logic signed [9:0] e;
`ifdef FPDIV_RNE_EN
    logic         guard, sticky;
    logic [23:0]  mant_inc;
`endif

    fp_div_special u_special (
        .n1        (n1),
        .n2        (n2),
        .special   (special),
        .sp_result (sp_result),
        .sp_exc    (sp_exc),
        .sp_dbz    (sp_dbz)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Exception = exc_q;
    assign DivByZero = dbz_q;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        b_d         = b_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        exc_d       = exc_q;
        dbz_d       = dbz_q;

        qbit    = (rem_q >= {2'b00, b_q});
        rem_sub = rem_q - {2'b00, b_q};
        mant    = '0;
        e       = '0;
`ifdef FPDIV_RNE_EN
        guard    = 1'b0;
        sticky   = 1'b0;
        mant_inc = '0;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (special) begin
                        result_d    = sp_result;
                        exc_d       = sp_exc;
                        dbz_d       = sp_dbz;
                        ovf_d       = 1'b0;
                        unf_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        rem_d   = {2'b00, 1'b1, n1[22:0]};
                        b_d     = {1'b1, n2[22:0]};
                        q_d     = '0;
                        cnt_d   = '0;
                        sign_d  = n1[31] ^ n2[31];
                        exp_d   = {2'b00, n1[30:23]} - {2'b00, n2[30:23]} + 10'(FP_BIAS);
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                // Remainder stays below 2*b, so the shifted-out top bit is always zero.
                rem_d = qbit ? {rem_sub[24:0], 1'b0} : {rem_q[24:0], 1'b0};
                q_d   = {q_q[24:0], qbit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(FPDIV_QBITS - 1)) state_d = NORM;
            end
            NORM: begin
                if (q_q[25]) begin
                    mant = q_q[24:2];
                    e    = exp_q;
                end else begin
                    mant = q_q[23:1];
                    e    = exp_q - 10'd1;
                end
`ifdef FPDIV_RNE_EN
                guard    = q_q[25] ? q_q[1] : q_q[0];
                sticky   = (q_q[25] & q_q[0]) | (rem_q != '0);
                mant_inc = {1'b0, mant} + 24'd1;
                if (guard && (sticky || mant[0])) begin
                    mant = mant_inc[22:0];
                    if (mant_inc[23]) e = e + 10'sd1;
                end
`endif
                ovf_d = 1'b0;
                unf_d = 1'b0;
                exc_d = 1'b0;
                dbz_d = 1'b0;
                if (e >= 10'sd255) begin
                    ovf_d    = 1'b1;
                    result_d = {sign_q, FP_EXP_MAX, 23'b0};
                end else if (e <= 10'sd0) begin
                    unf_d    = 1'b1;
                    result_d = {sign_q, 31'b0};
                end else begin
                    result_d = {sign_q, e[7:0], mant};
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            b_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            exc_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            b_q         <= b_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            exc_q       <= exc_d;
            dbz_q       <= dbz_d;
        end
    end

endmodule
